input_port: RTL and testbench
=============================

INPUT_PORT -- requirements
Module: input_port

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning consecutive stable synchronized samples required before a key's debounced state changes (legal range 2..65535).
REQ-002 SHALL have port iClock, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port iReset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port iKey, input, 4 bits: raw push-buttons, asynchronous, low = pressed.
REQ-005 SHALL have port iSwitch, input, 18 bits: raw slide switches, asynchronous.
REQ-006 SHALL have port iRead, input, 1 bit: CPU consume strobe, one cycle.
REQ-007 SHALL have port oData, output, 32 bits: captured event word.
REQ-008 SHALL have port oValid, output, 1 bit: oData holds an unread event.
REQ-009 SHALL have port oOverflow, output, 1 bit: sticky flag, set when an event was lost.
REQ-010 SHALL have port oKeyState, output, 4 bits: debounced key state, 1 = pressed.

Function
REQ-011 SHALL pass iKey and iSwitch through a 2-flop synchronizer before any use.
REQ-012 Per key SHALL use a 16-bit counter: synced sample equal to debounced state -> counter cleared; differing -> counter increments; on the cycle the counter equals DEBOUNCE_CYCLES-1 with the sample still differing -> debounced state takes the sample and the counter clears.
REQ-013 A press event SHALL be a debounced 0->1 transition of any key; several keys transitioning in the same cycle SHALL form one event.
REQ-014 Event word SHALL be: oData[17:0] = synced switches in the event cycle, oData[21:18] = one-hot OR of the keys pressed in that event, oData[25:22] = release field (see REQ-024), oData[31:26] = 0.
REQ-015 Holding register SHALL be a 2-state FSM, EMPTY and FULL; oValid = (state == FULL).
REQ-016 EMPTY + event -> load oData; next cycle is FULL with oValid = 1 (one-cycle latency from the debounced edge).
REQ-017 FULL + iRead and no event -> EMPTY next cycle; oData holds its last value.
REQ-018 FULL + iRead + event in the same cycle -> the new event is loaded, the FSM stays FULL, and no overflow is flagged.
REQ-019 FULL + event and no iRead -> oData is unchanged (oldest event kept) and oOverflow is set.
REQ-020 iRead while EMPTY SHALL be ignored, except that it clears oOverflow.
REQ-021 oOverflow SHALL clear on any iRead unless an overflow condition occurs in that same cycle (set wins).

Reset
REQ-022 Reset assertion SHALL asynchronously force: synchronizers to released/0, debounced states to 0, counters to 0, FSM to EMPTY, oData = 0, oValid = 0, oOverflow = 0, oKeyState = 0.
REQ-023 Reset mid-debounce or while FULL SHALL discard all pending state; a key held through reset release SHALL produce a press event after 2 + DEBOUNCE_CYCLES cycles.

Configuration
REQ-024 With macro INPUT_PORT_RELEASE_EN defined, debounced 1->0 transitions SHALL also be events, reported one-hot in oData[25:22], and one event MAY carry both press and release bits; without it, releases SHALL generate no event and oData[25:22] = 0.

Verification (DEBOUNCE_CYCLES = 4)
REQ-025 Drive iKey = 4'b1110 steady with iSwitch = 18'h2A5A5 -> oKeyState[0] = 1, oValid = 1, oData = 32'h0006A5A5.
REQ-026 Toggle iKey[1] every 2 cycles for 40 cycles -> oKeyState stays 0 and oValid stays 0.
REQ-027 Press KEY0, do not read, press KEY2 -> oData[21:18] = 4'b0001 and oOverflow = 1; pulse iRead -> oValid = 0 and oOverflow = 0.
REQ-028 Issue iRead in the exact cycle a new KEY3 event occurs while FULL -> oValid stays 1, oData[21:18] = 4'b1000, oOverflow = 0.
REQ-029 Assert iReset with oValid = 1 -> all outputs are 0 immediately, without waiting for a clock edge; release KEY0 -> with INPUT_PORT_RELEASE_EN, a release event with oData[22] = 1 is reported; without it, no event occurs.

Source files
------------

// File: rtl/input_port.sv
// -----------------------------------------------------------------------------
// input_port
//
// Purpose:
//    Front end for the board's push-buttons and slide switches.
//    - Both raw input groups pass through a 2-flop synchronizer before any use.
//    - Each key has its own counter-based debouncer.
//    - A debounced press (and, optionally, a release) captures an event word
//      into a one-deep holding register. The CPU consumes the word with iRead.
//    - An event that arrives while the register is full, with no read in the
//      same cycle, is dropped and sets a sticky overflow flag.
//
// Ports:
//    iClock     in   1   single clock, rising edge
//    iReset     in   1   asynchronous reset, active low
//    iKey       in   4   raw push-buttons, asynchronous, low = pressed
//    iSwitch    in  18   raw slide switches, asynchronous
//    iRead      in   1   one-cycle consume strobe from the CPU
//    oData      out 32   event word {6'b0, release[3:0], press[3:0], switches[17:0]}
//    oValid     out  1   oData holds an unread event
//    oOverflow  out  1   sticky, set when an event was lost
//    oKeyState  out  4   debounced key state, 1 = pressed
//
// Parameter:
//    DEBOUNCE_CYCLES  number of consecutive stable synchronized samples needed
//                     before a key's debounced state changes (2..65535)
//
// Configuration macro:
//    INPUT_PORT_RELEASE_EN  when defined, debounced releases are events too and
//                           are reported one-hot in oData[25:22]. When it is not
//                           defined, releases produce no event and that field
//                           reads 0.
// -----------------------------------------------------------------------------
module input_port #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic [3:0]  iKey,
   input  logic [17:0] iSwitch,
   input  logic        iRead,
   output logic [31:0] oData,
   output logic        oValid,
   output logic        oOverflow,
   output logic [3:0]  oKeyState
);

   localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   // ------------------------------------------------------------------------
   // Synchronizers. Keys reset to the released level (1); switches reset to 0.
   // ------------------------------------------------------------------------
   logic [3:0]  key_meta_q;
   logic [3:0]  key_sync_q;
   logic [17:0] sw_meta_q;
   logic [17:0] sw_sync_q;

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         key_meta_q <= '1;
         key_sync_q <= '1;
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
      end else begin
         key_meta_q <= iKey;
         key_sync_q <= key_meta_q;
         sw_meta_q  <= iSwitch;
         sw_sync_q  <= sw_meta_q;
      end
   end

   // ------------------------------------------------------------------------
   // Debounce, one counter per key. The counter measures how long the
   // synchronized sample has disagreed with the debounced state. When the
   // sample has disagreed for DEBOUNCE_CYCLES samples, the state follows it.
   // ------------------------------------------------------------------------
   logic [3:0]        key_pressed;
   logic [3:0][15:0]  cnt_q;
   logic [3:0][15:0]  cnt_d;
   logic [3:0]        deb_q;
   logic [3:0]        deb_d;
   logic [3:0]        deb_prev_q;

   assign key_pressed = ~key_sync_q;

   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         if (key_pressed[k] != deb_q[k]) begin
            if (cnt_q[k] == CNT_LAST) begin
               deb_d[k] = key_pressed[k];
            end else begin
               cnt_d[k] = cnt_q[k] + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         cnt_q      <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
      end
   end

   assign oKeyState = deb_q;

   // ------------------------------------------------------------------------
   // Event detection. Edges are taken between the registered debounced state
   // and its one-cycle-delayed copy. Any number of keys that change in the
   // same cycle form a single event.
   // ------------------------------------------------------------------------
   logic [3:0]  rise_w;
   logic [3:0]  fall_w;
   logic        event_w;
   logic [31:0] evt_word_w;

   assign rise_w = deb_q & ~deb_prev_q;

`ifdef INPUT_PORT_RELEASE_EN
   assign fall_w = deb_prev_q & ~deb_q;
`else
   assign fall_w = '0;
`endif

   assign event_w    = |(rise_w | fall_w);
   assign evt_word_w = {6'b0, fall_w, rise_w, sw_sync_q};

   // ------------------------------------------------------------------------
   // Holding register FSM.
   // When the register is full, a read in the same cycle as a new event frees
   // the slot for that event, so the event is not counted as an overflow.
   // ------------------------------------------------------------------------
   state_e      state_q;
   logic [31:0] data_q;
   logic        ovf_q;

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state_q <= EMPTY;
         data_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (event_w) begin
                  data_q  <= evt_word_w;
                  state_q <= FULL;
               end
            end
            FULL: begin
               if (event_w && iRead) begin
                  data_q  <= evt_word_w;
               end else if (!event_w && iRead) begin
                  state_q <= EMPTY;
               end
            end
            default: begin
               state_q <= EMPTY;
            end
         endcase

         // When the flag is set and cleared in the same cycle, the set wins.
         if ((state_q == FULL) && event_w && !iRead) begin
            ovf_q <= 1'b1;
         end else if (iRead) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign oData     = data_q;
   assign oValid    = (state_q == FULL);
   assign oOverflow = ovf_q;

endmodule

// File: tb/tb_input_port.sv
module tb_input_port;

   localparam int unsigned D = 4;

`ifdef INPUT_PORT_RELEASE_EN
   localparam bit REL = 1'b1;
`else
   localparam bit REL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  key;
   logic [17:0] sw;
   logic        rd;
   logic [31:0] oData;
   logic        oValid;
   logic        oOverflow;
   logic [3:0]  oKeyState;

   input_port #(.DEBOUNCE_CYCLES(D)) dut (
      .iClock    (clk),
      .iReset    (rst_n),
      .iKey      (key),
      .iSwitch   (sw),
      .iRead     (rd),
      .oData     (oData),
      .oValid    (oValid),
      .oOverflow (oOverflow),
      .oKeyState (oKeyState)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Reference model: a 2-deep delay line for the raw inputs, a run length of
   // disagreeing samples per key, and a one-slot mailbox with an overflow flag.
   logic [3:0]  m_kd1, m_kd2;
   logic [17:0] m_sd1, m_sd2;
   logic [3:0]  m_deb, m_prev;
   int unsigned m_run [4];
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ovf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_kd1 = 4'hF; m_kd2 = 4'hF;
      m_sd1 = '0;   m_sd2 = '0;
      m_deb = '0;   m_prev = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_data = '0; m_valid = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic model_step();
      logic [3:0] press, rel, pk;
      logic       ev;
      press = m_deb & ~m_prev;
      rel   = REL ? (m_prev & ~m_deb) : 4'b0;
      ev    = |(press | rel);
      if (m_valid && ev && !rd) m_ovf = 1'b1;
      else if (rd)              m_ovf = 1'b0;
      if (ev && (!m_valid || rd)) begin
         m_data  = {6'b0, rel, press, m_sd2};
         m_valid = 1'b1;
      end else if (m_valid && rd) begin
         m_valid = 1'b0;
      end
      m_prev = m_deb;
      pk = ~m_kd2;
      for (int k = 0; k < 4; k++) begin
         if (pk[k] == m_deb[k]) m_run[k] = 0;
         else begin
            m_run[k] = m_run[k] + 1;
            if (m_run[k] == D) begin
               m_deb[k] = pk[k];
               m_run[k] = 0;
            end
         end
      end
      m_kd2 = m_kd1; m_kd1 = key;
      m_sd2 = m_sd1; m_sd1 = sw;
   endtask

   task automatic chk_all();
      chk("oData",     oData,               m_data);
      chk("oValid",    32'(oValid),         32'(m_valid));
      chk("oOverflow", 32'(oOverflow),      32'(m_ovf));
      chk("oKeyState", 32'(oKeyState),      32'(m_deb));
   endtask

   task automatic cyc();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
      #1;
      chk_all();
   endtask

   task automatic wait_n(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic drain();
      if (m_valid) begin
         rd = 1'b1; cyc(); rd = 1'b0;
      end
   endtask

   initial begin
      logic seen;
      int   hold;
      rst_n = 1'b0; key = 4'hF; sw = '0; rd = 1'b0;
      model_reset();
      wait_n(3);
      chk("rst_data",  oData, 32'h0);
      chk("rst_valid", 32'(oValid), 32'h0);
      chk("rst_ovf",   32'(oOverflow), 32'h0);
      chk("rst_keys",  32'(oKeyState), 32'h0);
      rst_n = 1'b1;
      wait_n(2);

      // Single key press with a switch pattern.
      sw = 18'h2A5A5; key = 4'b1110;
      wait_n(10);
      chk("press_key0_state", 32'(oKeyState[0]), 32'h1);
      chk("press_key0_valid", 32'(oValid), 32'h1);
      chk("press_key0_data",  oData, 32'h0006A5A5);
      rd = 1'b1; cyc(); rd = 1'b0;
      chk("read_clears_valid", 32'(oValid), 32'h0);
      key = 4'hF;
      wait_n(10);
      drain();

      // Bouncing key never settles.
      for (int i = 0; i < 20; i++) begin
         key = (i % 2 == 0) ? 4'b1101 : 4'hF;
         wait_n(2);
      end
      wait_n(6);
      chk("bounce_keys",  32'(oKeyState), 32'h0);
      chk("bounce_valid", 32'(oValid), 32'h0);

      // Overflow: second event while full and unread.
      key = 4'b1110;
      wait_n(10);
      key = 4'b1010;
      wait_n(10);
      chk("ovf_press_field", 32'(oData[21:18]), 32'h1);
      chk("ovf_flag",        32'(oOverflow), 32'h1);
      rd = 1'b1; cyc(); rd = 1'b0;
      chk("ovf_read_valid", 32'(oValid), 32'h0);
      chk("ovf_read_flag",  32'(oOverflow), 32'h0);
      key = 4'hF;
      wait_n(10);
      drain();

      // Read coinciding with a new event while full.
      key = 4'b1110;
      wait_n(10);
      key = 4'b0110;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (m_deb[3] && !m_prev[3]) seen = 1'b1;
         else cyc();
      end
      chk("coincide_event_seen", 32'(seen), 32'h1);
      rd = 1'b1; cyc(); rd = 1'b0;
      chk("coincide_valid", 32'(oValid), 32'h1);
      chk("coincide_press", 32'(oData[21:18]), 32'h8);
      chk("coincide_ovf",   32'(oOverflow), 32'h0);

      // Asynchronous reset while full, keys 0 and 3 held through it.
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_data",  oData, 32'h0);
      chk("async_rst_valid", 32'(oValid), 32'h0);
      chk("async_rst_ovf",   32'(oOverflow), 32'h0);
      chk("async_rst_keys",  32'(oKeyState), 32'h0);
      model_reset();
      wait_n(3);
      rst_n = 1'b1;
      for (int i = 1; i <= int'(D) + 2; i++) begin
         cyc();
         if (i == int'(D) + 1) chk("held_keys_early", 32'(oKeyState), 32'h0);
      end
      chk("held_keys_settled", 32'(oKeyState), 32'h9);
      cyc();
      chk("held_event_valid", 32'(oValid), 32'h1);
      chk("held_event_press", 32'(oData[21:18]), 32'h9);
      drain();
      key = 4'b0111;
      wait_n(10);
      if (REL) begin
         chk("release_valid", 32'(oValid), 32'h1);
         chk("release_bit",   32'(oData[22]), 32'h1);
      end else begin
         chk("release_none", 32'(oValid), 32'h0);
      end
      drain();

      // Random traffic against the model.
      hold = 0;
      for (int i = 0; i < 600; i++) begin
         if (hold == 0) begin
            key  = key ^ 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 10);
         end else begin
            hold--;
         end
         sw = 18'($urandom);
         rd = ($urandom_range(0, 3) == 0);
         if (i == 300) rst_n = 1'b0;
         if (i == 303) rst_n = 1'b1;
         cyc();
      end
      rd = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
